// File: rtl/mem_responder_if.sv
// Processor-side memory request/response bundle for mem_responder.
// The master drives requests; the slave (responder) returns data and status.
interface mem_responder_if #(
   parameter int AW = 5,
   parameter int DW = 8
);
   logic [AW-1:0] adr;
   logic [DW-1:0] writeData;
   logic          memRead;
   logic          memWrite;
   logic [DW-1:0] readData;
   logic          memReady;
   logic          memErr;

   modport master (
      output adr, writeData, memRead, memWrite,
      input  readData, memReady, memErr
   );

   modport slave (
      input  adr, writeData, memRead, memWrite,
      output readData, memReady, memErr
   );
endinterface

// File: rtl/mem_responder.sv
// Single-port memory model with programmable wait states, one-cycle completion/error
// pulses, and a release handshake so a held request is serviced only once.
module mem_responder #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int          AW          = 5,
   parameter int          DW          = 8
) (
   input logic            clk,
   input logic            rst,
   mem_responder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE, RELEASE} state_t;

   state_t        state, state_nxt;
   logic [3:0]    cnt;
   logic [AW-1:0] adr_q;
   logic [DW-1:0] wd_q;
   logic          wr_q;
   logic          err_q;
   logic [DW-1:0] rdata_q;
   logic [DW-1:0] mem [2**AW];

   logic          one_req, both_req, go_done;
   logic [AW-1:0] acc_adr;
   logic [DW-1:0] acc_wd;
   logic          acc_wr;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // With zero wait states DONE is entered straight from IDLE, so the access
   // must use the live request inputs rather than the not-yet-latched copies.
   always_comb begin
      one_req   = bus.memRead ^ bus.memWrite;
      both_req  = bus.memRead & bus.memWrite;
      go_done   = 1'b0;
      acc_adr   = adr_q;
      acc_wd    = wd_q;
      acc_wr    = wr_q;
      state_nxt = state;
      case (state)
         IDLE: begin
            acc_adr = bus.adr;
            acc_wd  = bus.writeData;
            acc_wr  = bus.memWrite;
            if (both_req) begin
               state_nxt = RELEASE;
            end else if (one_req) begin
               if (WAIT_CYCLES == 0) begin
                  go_done   = 1'b1;
                  state_nxt = DONE;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt <= 4'd1) begin
               go_done   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = RELEASE;
         RELEASE: if (!bus.memRead && !bus.memWrite) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         err_q <= (state == IDLE) && both_req;
         if (state == IDLE && one_req) begin
            adr_q <= bus.adr;
            wd_q  <= bus.writeData;
            wr_q  <= bus.memWrite;
            cnt   <= 4'(WAIT_CYCLES);
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (go_done && !acc_wr) rdata_q <= mem[acc_adr];
      end
   end

   // Array is deliberately not cleared by reset; reset only blocks the commit.
   always_ff @(posedge clk) begin
      if (!rst && go_done && acc_wr) mem[acc_adr] <= acc_wd;
   end

   always_comb begin
      bus.memReady = (state == DONE);
      bus.memErr   = err_q;
      bus.readData = rdata_q;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed table, reset-abort sequences,
// and randomized traffic on a 2-wait-state and a 0-wait-state instance.
module tb_mem_responder;
   localparam int AW = 5;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_responder_if #(.AW(AW), .DW(DW)) bus0 ();
   mem_responder_if #(.AW(AW), .DW(DW)) bus1 ();

   mem_responder #(.WAIT_CYCLES(2), .AW(AW), .DW(DW)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   mem_responder #(.WAIT_CYCLES(0), .AW(AW), .DW(DW)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   int passed = 0;
   int total  = 0;
   logic [7:0] mdl [2][32];
   logic [7:0] last_rd [2];

   typedef struct {
      logic       rd;
      logic       wr;
      logic [4:0] a;
      logic [7:0] d;
      int         hold;
      logic       rdy;
      logic       err;
      logic [7:0] q;
   } vec_t;
   vec_t tbl [11];

   function automatic int lat_of(input int sel);
      return (sel == 0) ? 3 : 1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic set_req(input int sel, input logic rd, input logic wr,
                          input logic [4:0] a, input logic [7:0] d);
      if (sel == 0) begin
         bus0.memRead = rd; bus0.memWrite = wr; bus0.adr = a; bus0.writeData = d;
      end else begin
         bus1.memRead = rd; bus1.memWrite = wr; bus1.adr = a; bus1.writeData = d;
      end
   endtask

   task automatic get(input int sel, output logic r, output logic e, output logic [7:0] q);
      if (sel == 0) begin r = bus0.memReady; e = bus0.memErr; q = bus0.readData; end
      else          begin r = bus1.memReady; e = bus1.memErr; q = bus1.readData; end
   endtask

   task automatic scramble_inputs(input int sel);
      if (sel == 0) begin bus0.adr = 5'($urandom); bus0.writeData = 8'($urandom); end
      else          begin bus1.adr = 5'($urandom); bus1.writeData = 8'($urandom); end
   endtask

   // Waits for the sampling edge, then the response; holds the request 'hold'
   // extra cycles, releases it, and returns to an IDLE-ready negedge.
   task automatic wait_resp(input int sel, input int hold, input bit scramble,
                            output logic g_rdy, output logic g_err, output int lat,
                            output int extra, output logic [7:0] q_resp, output logic [7:0] q_end);
      logic r, e;
      logic [7:0] q;
      g_rdy = 1'b0; g_err = 1'b0; lat = 99; extra = 0; q_resp = '0;
      @(posedge clk);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         get(sel, r, e, q);
         if (i == 1 && scramble) scramble_inputs(sel);
         if (r && e) extra++;
         if (r || e) begin
            g_rdy = r; g_err = e; lat = i; q_resp = q;
            break;
         end
      end
      for (int h = 0; h <= hold; h++) begin
         @(negedge clk);
         get(sel, r, e, q);
         if (r || e) extra++;
      end
      set_req(sel, 1'b0, 1'b0, 5'($urandom), 8'($urandom));
      @(negedge clk);
      get(sel, r, e, q);
      if (r || e) extra++;
      q_end = q;
   endtask

   task automatic run_model(input int sel, input logic rd, input logic wr, input logic [4:0] a,
                            input logic [7:0] d, input int hold, input bit scramble, input string tag);
      logic g_rdy, g_err;
      int lat, extra;
      logic [7:0] q_resp, q_end;
      bit is_err;
      is_err = rd && wr;
      set_req(sel, rd, wr, a, d);
      wait_resp(sel, hold, scramble, g_rdy, g_err, lat, extra, q_resp, q_end);
      if (!is_err && wr) mdl[sel][a] = d;
      if (!is_err && rd) last_rd[sel] = mdl[sel][a];
      chk({tag, " kind"}, {g_rdy, g_err}, is_err ? 2'b01 : 2'b10);
      chk({tag, " latency"}, lat, is_err ? 1 : lat_of(sel));
      if (!is_err && rd) chk({tag, " rdata"}, q_resp, mdl[sel][a]);
      chk({tag, " rdata hold"}, q_end, last_rd[sel]);
      chk({tag, " extra pulses"}, extra, 0);
   endtask

   // Write 3C to 10 on dut0, assert reset at the edge ending cycle at_i after sampling.
   task automatic rst_abort(input int at_i, input string tag);
      logic r, e;
      logic [7:0] q;
      int seen;
      seen = 0;
      set_req(0, 1'b0, 1'b1, 5'h10, 8'h3C);
      @(posedge clk);
      for (int i = 1; i <= at_i; i++) begin
         @(negedge clk);
         get(0, r, e, q);
         if (r || e) seen++;
      end
      rst = 1'b1;
      set_req(0, 1'b0, 1'b0, 5'h00, 8'h00);
      @(negedge clk);
      get(0, r, e, q);
      chk({tag, " readData cleared"}, q, 8'h00);
      rst = 1'b0;
      if (r || e) seen++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         get(0, r, e, q);
         if (r || e) seen++;
      end
      chk({tag, " no pulse"}, seen, 0);
      last_rd[0] = '0;
      last_rd[1] = '0;
   endtask

   initial begin
      logic r, e;
      logic [7:0] q;
      logic g_rdy, g_err;
      int lat, extra;
      logic [7:0] q_resp, q_end;

      tbl[0]  = '{1'b0, 1'b1, 5'h03, 8'hA5, 0, 1'b1, 1'b0, 8'h00};
      tbl[1]  = '{1'b1, 1'b0, 5'h03, 8'h00, 6, 1'b1, 1'b0, 8'hA5};
      tbl[2]  = '{1'b0, 1'b1, 5'h10, 8'h11, 0, 1'b1, 1'b0, 8'hA5};
      tbl[3]  = '{1'b1, 1'b1, 5'h10, 8'h77, 2, 1'b0, 1'b1, 8'hA5};
      tbl[4]  = '{1'b1, 1'b0, 5'h10, 8'h00, 0, 1'b1, 1'b0, 8'h11};
      tbl[5]  = '{1'b0, 1'b1, 5'h00, 8'h01, 0, 1'b1, 1'b0, 8'h11};
      tbl[6]  = '{1'b1, 1'b0, 5'h00, 8'h00, 0, 1'b1, 1'b0, 8'h01};
      tbl[7]  = '{1'b0, 1'b1, 5'h1F, 8'h5A, 1, 1'b1, 1'b0, 8'h01};
      tbl[8]  = '{1'b1, 1'b0, 5'h1F, 8'h00, 0, 1'b1, 1'b0, 8'h5A};
      tbl[9]  = '{1'b1, 1'b1, 5'h1F, 8'hFF, 0, 1'b0, 1'b1, 8'h5A};
      tbl[10] = '{1'b1, 1'b0, 5'h1F, 8'h00, 3, 1'b1, 1'b0, 8'h5A};

      set_req(0, 1'b0, 1'b0, 5'h00, 8'h00);
      set_req(1, 1'b0, 1'b0, 5'h00, 8'h00);
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         get(s, r, e, q);
         chk($sformatf("reset%0d readData", s), q, 8'h00);
         chk($sformatf("reset%0d memReady", s), r, 1'b0);
         chk($sformatf("reset%0d memErr", s), e, 1'b0);
      end
      rst = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;

      for (int i = 0; i < 11; i++) begin
         set_req(0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
         wait_resp(0, tbl[i].hold, 1'b0, g_rdy, g_err, lat, extra, q_resp, q_end);
         chk($sformatf("tbl%0d kind", i), {g_rdy, g_err}, {tbl[i].rdy, tbl[i].err});
         chk($sformatf("tbl%0d latency", i), lat, tbl[i].err ? 1 : 3);
         if (tbl[i].rdy && tbl[i].rd) chk($sformatf("tbl%0d rdata", i), q_resp, tbl[i].q);
         chk($sformatf("tbl%0d rdata hold", i), q_end, tbl[i].q);
         chk($sformatf("tbl%0d extra pulses", i), extra, 0);
         if (tbl[i].wr && !tbl[i].rd) mdl[0][tbl[i].a] = tbl[i].d;
         last_rd[0] = tbl[i].q;
      end

      for (int a = 0; a < 32; a++)
         for (int s = 0; s < 2; s++)
            run_model(s, 1'b0, 1'b1, 5'(a), 8'($urandom), 0, 1'b1, $sformatf("init%0d_%0d", s, a));

      run_model(0, 1'b0, 1'b1, 5'h10, 8'h11, 0, 1'b0, "pre_abort write");
      rst_abort(1, "abort_wait");
      run_model(0, 1'b1, 1'b0, 5'h10, 8'h00, 0, 1'b0, "abort_wait readback");
      rst_abort(2, "abort_done_entry");
      run_model(0, 1'b1, 1'b0, 5'h10, 8'h00, 0, 1'b0, "abort_done readback");

      rst = 1'b1;
      set_req(0, 1'b1, 1'b0, 5'h10, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;
      wait_resp(0, 0, 1'b0, g_rdy, g_err, lat, extra, q_resp, q_end);
      chk("held_after_rst kind", {g_rdy, g_err}, 2'b10);
      chk("held_after_rst latency", lat, 3);
      chk("held_after_rst rdata", q_resp, 8'h11);
      last_rd[0] = 8'h11;

      run_model(1, 1'b0, 1'b1, 5'h1F, 8'hC3, 0, 1'b0, "w0 write 1F");
      run_model(1, 1'b1, 1'b0, 5'h1F, 8'h00, 0, 1'b1, "w0 read 1F scrambled");

      for (int n = 0; n < 150; n++) begin
         int s, k;
         s = int'($urandom_range(1, 0));
         k = int'($urandom_range(7, 0));
         run_model(s, (k < 4) || (k == 7), (k >= 4), 5'($urandom), 8'($urandom),
                   int'($urandom_range(3, 0)), 1'($urandom), $sformatf("rnd%0d", n));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
